// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared helpers for the push-button debouncer
package btn_debounce_pkg;

  // Stable-time length in clock cycles, never below one cycle.
  function automatic int deb_cycles_f(input int clk_fre, input int deb_ms);
    int cycles;
    cycles = (clk_fre / 1000) * deb_ms;
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - single-channel debouncer: 2-FF synchronizer, stability counter, output flop
module btn_debounce_ch #(
  parameter int DEB_CYCLES = 1,
  parameter int CW         = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_in,
  output logic btn_out
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the output restarts the stability count.
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    if (s2_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      out_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      cnt_q <= '0;
      out_q <= 1'b1;
    end else begin
      s1_q  <= btn_in;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign btn_out = out_q;

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - multi-channel active-low push-button debouncer
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int BT_WIDTH = 3,
  parameter int CLK_FRE  = 50_000_000,
  parameter int DEB_MS   = 20
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [BT_WIDTH-1:0] btn_in,
  output logic [BT_WIDTH-1:0] btn_out
);

  localparam int DEB_CYCLES = deb_cycles_f(CLK_FRE, DEB_MS);
  localparam int CW         = $clog2(DEB_CYCLES + 1);

  for (genvar i = 0; i < BT_WIDTH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .CW         (CW)
    ) u_ch (
      .clk     (clk),
      .rstn    (rstn),
      .btn_in  (btn_in[i]),
      .btn_out (btn_out[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - randomized and directed bench for btn_debounce against a sliding-window model
module tb_btn_debounce;

  localparam int HN = 22;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] btn_in = 3'b000;
  logic [2:0] out20, out1;
  logic [2:0] exp20 = 3'b111;
  logic [2:0] exp1  = 3'b111;
  logic [2:0] h20 [0:HN-1];
  logic [2:0] h1  [0:HN-1];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btn_debounce #(.BT_WIDTH(3), .CLK_FRE(1000), .DEB_MS(20)) u_dut20 (
    .clk(clk), .rstn(rstn), .btn_in(btn_in), .btn_out(out20)
  );
  btn_debounce #(.BT_WIDTH(3), .CLK_FRE(1000), .DEB_MS(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .btn_in(btn_in), .btn_out(out1)
  );

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // A channel flips when the last deb synchronized samples all disagree with it.
  // h[0] holds btn_in from the previous edge (s1), h[k] the sample k edges older.
  function automatic logic [2:0] deb_step(input logic [2:0] h [0:HN-1], input int deb,
                                          input logic [2:0] o);
    logic [2:0] r;
    r = o;
    for (int i = 0; i < 3; i++) begin
      bit all_differ;
      all_differ = 1'b1;
      for (int k = 1; k <= deb; k++)
        if (h[k][i] == o[i]) all_differ = 1'b0;
      if (all_differ) r[i] = ~o[i];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp20 = 3'b111;
      exp1  = 3'b111;
      for (int k = 0; k < HN; k++) begin
        h20[k] = 3'b111;
        h1[k]  = 3'b111;
      end
    end else begin
      exp20 = deb_step(h20, 20, exp20);
      exp1  = deb_step(h1, 1, exp1);
      for (int k = HN - 1; k > 0; k--) begin
        h20[k] = h20[k-1];
        h1[k]  = h1[k-1];
      end
      h20[0] = btn_in;
      h1[0]  = btn_in;
    end
  end

  always @(negedge clk) begin
    check("model_deb20", out20, exp20);
    check("model_deb1", out1, exp1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(5);
    check("rst_hold", out20, 3'b111);
    rstn = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      cyc(1);
      check("rst_release_hold", out20, 3'b111);
    end
    cyc(1);
    check("rst_release_fall", out20, 3'b000);

    btn_in = 3'b111;
    cyc(30);
    check("idle_released", out20, 3'b111);

    btn_in = 3'b110;
    cyc(21);
    check("press_early", out20, 3'b111);
    cyc(1);
    check("press_latency", out20, 3'b110);
    btn_in = 3'b111;
    cyc(21);
    check("release_early", out20, 3'b110);
    cyc(1);
    check("release_latency", out20, 3'b111);

    cyc(5);
    btn_in[1] = 1'b0;
    cyc(19);
    btn_in[1] = 1'b1;
    cyc(30);
    check("glitch19", out20, 3'b111);

    btn_in[1] = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      cyc(1);
      if (k == 20) btn_in[1] = 1'b1;
      if (k == 21) check("pulse20_pre", out20, 3'b111);
      if (k == 22) check("pulse20_low", out20, 3'b101);
      if (k == 41) check("pulse20_end", out20, 3'b101);
      if (k == 42) check("pulse20_back", out20, 3'b111);
    end

    for (int s = 0; s < 12; s++) begin
      btn_in[2] = (s % 2 == 0) ? 1'b0 : 1'b1;
      cyc(5);
      check("bounce_hold", out20, 3'b111);
    end
    btn_in[2] = 1'b0;
    cyc(21);
    check("bounce_early", out20, 3'b111);
    cyc(1);
    check("bounce_settle", out20, 3'b011);

    btn_in = 3'b111;
    cyc(30);
    btn_in = 3'b000;
    cyc(21);
    check("simul_early", out20, 3'b111);
    cyc(1);
    check("simul_fall", out20, 3'b000);
    btn_in = 3'b001;
    cyc(21);
    check("bit0_rel_early", out20, 3'b000);
    cyc(1);
    check("bit0_rel", out20, 3'b001);

    btn_in = 3'b111;
    cyc(5);
    btn_in = 3'b010;
    cyc(2);
    check("deb1_early", out1, 3'b111);
    cyc(1);
    check("deb1_follow", out1, 3'b010);

    btn_in = 3'b000;
    cyc(10);
    #2 rstn = 1'b0;
    #1 check("async_rst20", out20, 3'b111);
    check("async_rst1", out1, 3'b111);
    cyc(1);
    rstn = 1'b1;
    cyc(21);
    check("rst_mid_early", out20, 3'b111);
    cyc(1);
    check("rst_mid_fall", out20, 3'b000);

    for (int it = 0; it < 200; it++) begin
      btn_in = 3'($urandom);
      if ($urandom_range(0, 30) == 0) begin
        rstn = 1'b0;
        cyc(1);
        rstn = 1'b1;
      end
      cyc($urandom_range(1, 25));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
